// File: rtl/countdown_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : countdown_pkg
//  Purpose  : Shared types and helpers for the countdown_timer block.
//             State encoding for the timer FSM and the width helper for the
//             prescale counter.
//  Revision : 1.0 - initial release
// ============================================================================
package countdown_pkg;

    // Timer states; 2-bit encoding stored directly in the state register.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } cd_state_t;

    // Width of the prescale counter: enough bits to hold PRESCALE-1,
    // never less than one bit so PRESCALE=1 still has a legal vector.
    function automatic int prescale_width(input int prescale);
        if (prescale <= 2) begin
            return 1;
        end
        return $clog2(prescale);
    endfunction

endpackage : countdown_pkg
`default_nettype wire

// File: rtl/countdown_timer_tick_prescaler.sv
`default_nettype none
// ============================================================================
//  Module   : tick_prescaler
//  Purpose  : Divides the clock by PRESCALE while 'run' is high. 'strobe'
//             marks the cycle whose edge should decrement the timer. The
//             count holds whenever 'run' is low, which gives the parent an
//             exact pause/resume without extra bookkeeping. 'clr' restarts
//             the division from zero.
//  Revision : 1.0 - initial release
// ============================================================================
module tick_prescaler
    import countdown_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clr,
    output logic strobe
);

    localparam int             c_W    = prescale_width(PRESCALE);
    localparam logic [c_W-1:0] c_LAST = c_W'(PRESCALE - 1);
    localparam logic [c_W-1:0] c_ONE  = c_W'(1);

    logic [c_W-1:0] r_cnt;
    logic           w_at_last;

    assign w_at_last = (r_cnt == c_LAST);
    assign strobe    = run && w_at_last;

    // Prescale count: clear on request, advance only while running,
    // wrap to zero on the strobe cycle, otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= w_at_last ? '0 : (r_cnt + c_ONE);
        end
    end

endmodule : tick_prescaler
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module   : countdown_timer
//  Purpose  : Loadable down-counter. A loaded value is counted down once
//             every PRESCALE clocks after 'start'; 'pause' freezes the count
//             and prescale phase, a later 'start' resumes exactly. On expiry
//             q reaches 0 and zero_tick pulses for one cycle.
//  Options  : COUNTDOWN_AUTO_RELOAD_EN - on expiry reload q from the value
//             captured at the last accepted load and keep running (a zero
//             reload value still finishes in DONE).
//  Revision : 1.0 - initial release
// ============================================================================
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int N        = 8,
    parameter int PRESCALE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         start,
    input  logic         pause,
    output logic [N-1:0] q,
    output logic         busy,
    output logic         zero_tick
);

    localparam logic [N-1:0] c_ONE = N'(1);

    cd_state_t    r_state;
    logic [N-1:0] r_q;
    logic         r_zero_tick;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [N-1:0] r_reload;
`endif

    logic w_q_zero;
    logic w_is_run;
    logic w_run;
    logic w_start_ok;
    logic w_clr;
    logic w_strobe;

    // Decode of current state and the start qualification shared by the
    // FSM and the prescaler. Load outranks start in every non-RUN state,
    // and a start on an empty count is ignored.
    assign w_q_zero   = (r_q == '0);
    assign w_is_run   = (r_state == RUN);
    assign w_run      = w_is_run && !pause;
    assign w_start_ok = !w_is_run && !load && start && !w_q_zero;
    // Resuming from HOLD keeps the prescale phase; a fresh start restarts it.
    assign w_clr      = w_start_ok && (r_state != HOLD);

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .run    (w_run),
        .clr    (w_clr),
        .strobe (w_strobe)
    );

    // Timer FSM together with the count, expiry pulse and reload registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_q         <= '0;
            r_zero_tick <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            r_reload    <= '0;
`endif
        end else begin
            r_zero_tick <= 1'b0;
            case (r_state)
                RUN: begin
                    if (pause) begin
                        r_state <= HOLD;
                    end else if (w_strobe && !w_q_zero) begin
                        if (r_q == c_ONE) begin
                            r_zero_tick <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                            if (r_reload != '0) begin
                                r_q <= r_reload;
                            end else begin
                                r_q     <= '0;
                                r_state <= DONE;
                            end
`else
                            r_q     <= '0;
                            r_state <= DONE;
`endif
                        end else begin
                            r_q <= r_q - c_ONE;
                        end
                    end
                end
                default: begin
                    // IDLE, HOLD and DONE share the load > start priority.
                    if (load) begin
                        r_q     <= load_val;
                        r_state <= IDLE;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                        r_reload <= load_val;
`endif
                    end else if (w_start_ok) begin
                        r_state <= RUN;
                    end
                end
            endcase
        end
    end

    assign q         = r_q;
    assign busy      = (r_state == RUN) || (r_state == HOLD);
    assign zero_tick = r_zero_tick;

endmodule : countdown_timer
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_countdown_timer
//  Purpose  : Directed self-checking bench for countdown_timer. Two
//             instances: PRESCALE=1 (u_p1) and PRESCALE=4 (u_p4), sharing
//             clock and reset, each with its own control inputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_countdown_timer;

    logic       clk;
    logic       reset;

    logic       ld1, st1, pa1;
    logic [7:0] lv1;
    logic [7:0] q1;
    logic       busy1, zt1;

    logic       ld4, st4, pa4;
    logic [7:0] lv4;
    logic [7:0] q4;
    logic       busy4, zt4;

    int errors = 0;
    int checks = 0;

    countdown_timer #(.N(8), .PRESCALE(1)) u_p1 (
        .clk       (clk),
        .reset     (reset),
        .load      (ld1),
        .load_val  (lv1),
        .start     (st1),
        .pause     (pa1),
        .q         (q1),
        .busy      (busy1),
        .zero_tick (zt1)
    );

    countdown_timer #(.N(8), .PRESCALE(4)) u_p4 (
        .clk       (clk),
        .reset     (reset),
        .load      (ld4),
        .load_val  (lv4),
        .start     (st4),
        .pause     (pa4),
        .q         (q4),
        .busy      (busy4),
        .zero_tick (zt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int zt_count;
        int exp_q;

        reset = 1'b1;
        ld1 = 0; st1 = 0; pa1 = 0; lv1 = 8'h00;
        ld4 = 0; st4 = 0; pa4 = 0; lv4 = 8'h00;
        step();
        step();
        reset = 1'b0;

        // Reset state
        chk("rst_q",    32'(q1), 32'h0);
        chk("rst_busy", 32'(busy1), 32'h0);
        chk("rst_zt",   32'(zt1), 32'h0);
        chk("rst_q4",   32'(q4), 32'h0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        // Auto-reload on PRESCALE=4: load 3 -> expiry every 12 cycles, q reloads to 3.
        ld4 = 1; lv4 = 8'd3;
        step();
        ld4 = 0; st4 = 1;
        step();                             // start edge k
        st4 = 0;
        repeat (11) step();
        chk("ar_pre_q", 32'(q4), 32'd1);
        chk("ar_pre_zt", 32'(zt4), 32'h0);
        step();                             // k+12
        chk("ar_zt1", 32'(zt4), 32'h1);
        chk("ar_q_reload", 32'(q4), 32'd3);
        chk("ar_busy", 32'(busy4), 32'h1);
        repeat (12) step();                 // k+24
        chk("ar_zt2", 32'(zt4), 32'h1);
        pa4 = 1;
        step();
        pa4 = 0;
        zt_count = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (zt4) zt_count++;
        end
        chk("ar_pause_no_tick", 32'(zt_count), 32'd0);
        chk("ar_hold_busy", 32'(busy4), 32'h1);
        // Load 0 from HOLD, then start must be ignored.
        ld4 = 1; lv4 = 8'd0;
        step();
        ld4 = 0; st4 = 1;
        step();
        st4 = 0;
        step();
        chk("ar_zero_start_busy", 32'(busy4), 32'h0);
        chk("ar_zero_start_q", 32'(q4), 32'h0);
`else
        // ---- Test 1: PRESCALE=1, load 5, start, count 5..0 ----
        ld1 = 1; lv1 = 8'd5;
        step();
        chk("t1_load_q", 32'(q1), 32'd5);
        chk("t1_load_busy", 32'(busy1), 32'h0);
        ld1 = 0; st1 = 1;
        step();                             // start edge: RUN, no decrement yet
        st1 = 0;
        chk("t1_start_q", 32'(q1), 32'd5);
        chk("t1_start_busy", 32'(busy1), 32'h1);
        for (int v = 4; v >= 1; v--) begin
            step();
            chk("t1_q", 32'(q1), 32'(v));
            chk("t1_zt_low", 32'(zt1), 32'h0);
            chk("t1_busy_run", 32'(busy1), 32'h1);
        end
        step();
        chk("t1_q0", 32'(q1), 32'h0);
        chk("t1_zt", 32'(zt1), 32'h1);
        chk("t1_busy_fall", 32'(busy1), 32'h0);
        step();
        chk("t1_zt_once", 32'(zt1), 32'h0);
        chk("t1_q_hold0", 32'(q1), 32'h0);
        // Start from DONE with q==0 is ignored.
        st1 = 1;
        step();
        st1 = 0;
        step();
        chk("t1_done_start_busy", 32'(busy1), 32'h0);
        chk("t1_done_start_zt", 32'(zt1), 32'h0);
        chk("t1_done_start_q", 32'(q1), 32'h0);

        // ---- Test 3: simultaneous start/pause/load in RUN, load in RUN ----
        ld1 = 1; lv1 = 8'd10;
        step();
        ld1 = 0; st1 = 1;
        step();                             // RUN, q=10
        st1 = 1; pa1 = 1; ld1 = 1; lv1 = 8'd99;
        step();                             // pause wins -> HOLD, q frozen
        st1 = 0; pa1 = 0; ld1 = 0;
        chk("t3_spl_q", 32'(q1), 32'd10);
        chk("t3_spl_busy", 32'(busy1), 32'h1);
        step();
        chk("t3_hold_q", 32'(q1), 32'd10);
        st1 = 1;
        step();                             // resume edge
        st1 = 0; ld1 = 1; lv1 = 8'd77;
        step();                             // load ignored in RUN, decrement
        ld1 = 0;
        chk("t3_run_load_q", 32'(q1), 32'd9);
        chk("t3_run_load_busy", 32'(busy1), 32'h1);

        // ---- Test 4: asynchronous reset mid-count ----
        ld1 = 1; lv1 = 8'h40;
        // q1 is in RUN (load ignored); pause first so the load is accepted.
        ld1 = 0; pa1 = 1;
        step();
        pa1 = 0; ld1 = 1;
        step();
        ld1 = 0; st1 = 1;
        step();                             // RUN with q=0x40
        st1 = 0;
        chk("t4_run_q", 32'(q1), 32'h40);
        step();
        step();
        step();
        chk("t4_mid_q", 32'(q1), 32'h3D);
        #3;                                 // between edges
        reset = 1'b1;
        #1;
        chk("t4_async_q", 32'(q1), 32'h0);
        chk("t4_async_busy", 32'(busy1), 32'h0);
        chk("t4_async_zt", 32'(zt1), 32'h0);
        step();
        reset = 1'b0;
        step();
        step();
        chk("t4_after_q", 32'(q1), 32'h0);
        chk("t4_after_busy", 32'(busy1), 32'h0);
        st1 = 1;                            // start without a load: q==0, ignored
        step();
        st1 = 0;
        chk("t4_start_q0_busy", 32'(busy1), 32'h0);
        ld1 = 1; lv1 = 8'd2;
        step();
        ld1 = 0; st1 = 1;
        step();
        st1 = 0;
        chk("t4_restart_busy", 32'(busy1), 32'h1);
        step();
        step();
        chk("t4_restart_zt", 32'(zt1), 32'h1);
        step();

        // ---- Test 6: load 0xFF, 255 decrements, one tick, no wrap ----
        ld1 = 1; lv1 = 8'hFF;
        step();
        ld1 = 0; st1 = 1;
        step();
        st1 = 0;
        exp_q = 255;
        zt_count = 0;
        for (int i = 0; i < 260; i++) begin
            step();
            if (exp_q > 0) exp_q--;
            if (zt1) zt_count++;
            chk("t6_q", 32'(q1), 32'(exp_q));
        end
        chk("t6_one_tick", 32'(zt_count), 32'd1);
        chk("t6_busy", 32'(busy1), 32'h0);

        // ---- Test 2: PRESCALE=4 pause/resume with exact phase ----
        ld4 = 1; lv4 = 8'd3;
        step();
        ld4 = 0; st4 = 1;
        step();                             // start edge k
        st4 = 0;
        step(); step(); step();             // k+1..k+3
        chk("t2_pre_q", 32'(q4), 32'd3);
        step();                             // k+4: first decrement
        chk("t2_dec1_q", 32'(q4), 32'd2);
        step();                             // k+5: prescale phase 1
        pa4 = 1;
        step();                             // k+6: HOLD, q=2, phase 1 frozen
        pa4 = 0;
        repeat (10) step();
        chk("t2_hold_q", 32'(q4), 32'd2);
        chk("t2_hold_busy", 32'(busy4), 32'h1);
        st4 = 1;
        step();                             // resume edge r
        st4 = 0;
        // 5 of the 12 counting edges were spent before the pause; 7 remain.
        step(); step(); step();             // r+3
        chk("t2_res_dec_q", 32'(q4), 32'd1);
        step(); step(); step();             // r+6
        chk("t2_r6_q", 32'(q4), 32'd1);
        chk("t2_r6_zt", 32'(zt4), 32'h0);
        step();                             // r+7
        chk("t2_r7_q", 32'(q4), 32'd0);
        chk("t2_r7_zt", 32'(zt4), 32'h1);
        chk("t2_r7_busy", 32'(busy4), 32'h0);
        step();
        chk("t2_zt_once", 32'(zt4), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_countdown_timer
`default_nettype wire
